// File: rtl/instruction_feeder_if.sv
// Bundle between the instruction feeder, its loader/controller and the processor.
// Latency: none, this is wiring only.
// Backpressure: none here; Done from the processor paces issue inside the feeder.
interface instruction_feeder_if #(
    parameter int AW = 5
);
    // loader / controller side
    logic          Load_en;
    logic [AW-1:0] Load_addr;
    logic [15:0]   Load_data;
    logic [AW:0]   Prog_len;
    logic          Start;
    // processor side
    logic          Done;
    logic [15:0]   DIN;
    logic          Run;
    // status
    logic          Busy;
    logic          Finished;
    logic          Error;
    logic [AW:0]   Pc;
    logic [7:0]    Instr_count;

    // The feeder drives the processor-facing bus and status.
    modport master (
        input  Load_en, Load_addr, Load_data, Prog_len, Start, Done,
        output DIN, Run, Busy, Finished, Error, Pc, Instr_count
    );

    // The environment (controller plus processor) on the other side.
    modport slave (
        output Load_en, Load_addr, Load_data, Prog_len, Start, Done,
        input  DIN, Run, Busy, Finished, Error, Pc, Instr_count
    );
endinterface

// File: rtl/instruction_feeder.sv
// Feeds a stored program to the processor over DIN/Run/Done, one instruction at a time.
// Latency: Run rises 2 cycles after Start; next fetch starts the cycle after Done is seen.
// Backpressure: each instruction stalls in WAIT until Done, or until TIMEOUT cycles flag Error.
module instruction_feeder #(
    parameter int         DEPTH   = 32,
    parameter int         AW      = 5,
    parameter int         TIMEOUT = 15,
    parameter logic [2:0] OP_MVI  = 3'b001
) (
    input  logic Clock,
    input  logic Reset,
    instruction_feeder_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_IMM,
        S_WAIT,
        S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   din_q, din_d;
    logic          run_q, run_d;
    logic          busy_q, busy_d;
    logic          finished_q, finished_d;
    logic          error_q, error_d;
    logic          mvi_q, mvi_d;
    logic [AW:0]   pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;

    // Program storage; contents deliberately survive Reset.
    logic [15:0]   mem [DEPTH];
    logic          wr_en;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;
    logic [AW:0]   pc_inc1;
    logic [AW:0]   pc_next;

    // During ISSUE the read port looks one word ahead so the mvi immediate is ready for IMM.
    assign pc_inc1 = pc_q + (AW+1)'(1);
    assign pc_next = mvi_q ? (pc_q + (AW+1)'(2)) : pc_inc1;
    assign rd_addr = (state_q == S_ISSUE) ? pc_inc1[AW-1:0] : pc_q[AW-1:0];
    assign rd_data = mem[rd_addr];

    // Program memory write port, usable only while idle and not starting.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[bus.Load_addr] <= bus.Load_data;
        end
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        din_d      = din_q;
        run_d      = 1'b0;
        finished_d = finished_q;
        error_d    = error_q;
        mvi_d      = mvi_q;
        pc_d       = pc_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        wr_en      = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.Start) begin
                    // Start takes priority over a simultaneous load.
                    len_d   = bus.Prog_len;
                    pc_d    = '0;
                    error_d = 1'b0;
                    cnt_d   = '0;
                    if (bus.Prog_len == '0) begin
                        finished_d = 1'b1;
                        state_d    = S_HALT;
                    end else begin
                        finished_d = 1'b0;
                        state_d    = S_FETCH;
                    end
                end else if (state_q == S_IDLE && bus.Load_en) begin
                    wr_en = 1'b1;
                end
            end
            S_FETCH: begin
                // din_q acts as the registered read port; Run launches with the word.
                din_d   = rd_data;
                run_d   = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                tmo_d = '0;
                if (din_q[8:6] == OP_MVI) begin
                    mvi_d = 1'b1;
                    if (pc_inc1 < len_q) begin
                        din_d   = rd_data;
                        state_d = S_IMM;
                    end else begin
                        // mvi with its immediate beyond the program end.
                        error_d = 1'b1;
                        state_d = S_HALT;
                    end
                end else begin
                    mvi_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_IMM: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.Done) begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);
                    pc_d  = pc_next;
                    if (pc_next >= len_q) begin
                        finished_d = 1'b1;
                        state_d    = S_HALT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    // TIMEOUT full WAIT cycles elapsed without Done.
                    error_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            din_q      <= '0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            error_q    <= 1'b0;
            mvi_q      <= 1'b0;
            pc_q       <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            din_q      <= din_d;
            run_q      <= run_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
            error_q    <= error_d;
            mvi_q      <= mvi_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.DIN         = din_q;
    assign bus.Run         = run_q;
    assign bus.Busy        = busy_q;
    assign bus.Finished    = finished_q;
    assign bus.Error       = error_q;
    assign bus.Pc          = pc_q;
    assign bus.Instr_count = cnt_q;
endmodule

// File: tb/tb_instruction_feeder.sv
// Randomised bench for instruction_feeder with a program-level reference model and scoreboard.
// Latency: Run timing and Done-to-halt offsets are checked against the model.
// Backpressure: a responder models the processor, answering each Run after a chosen delay.
module tb_instruction_feeder;
    localparam int DEPTH   = 32;
    localparam int AW      = 5;
    localparam int TIMEOUT = 15;

    logic Clock = 1'b0;
    logic Reset;

    instruction_feeder_if #(.AW(AW)) bus ();

    instruction_feeder #(
        .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT), .OP_MVI(3'b001)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] din;
        int          pc;
        bit          has_imm;
        logic [15:0] imm;
    } issue_t;

    typedef struct {
        bit fin;
        bit err;
        int cnt;
        int pc;
        int off;
    } end_t;

    issue_t      issue_q[$];
    end_t        end_q[$];
    int          delay_q[$];
    logic [15:0] mem_m [DEPTH];
    bit          in_idle = 1'b1;
    bit          armed   = 1'b0;
    int          fixed_k = 3;
    int          n_cmp   = 0;
    int          n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Processor response delay (cycles from Run to Done); 0 means Done never comes.
    function automatic int pick_k(input int mode, input int ws);
        if (mode == 2) return 0;
        if (mode == 3) return fixed_k;
        if (mode == 1 && $urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 4))
                0:       return ws - 1;
                1:       return ws;
                2:       return ws + TIMEOUT - 1;
                3:       return ws + TIMEOUT;
                default: return 0;
            endcase
        end
        return ws + $urandom_range(0, 4);
    endfunction

    // Walk the program as the processor would see it and record what must appear.
    task automatic model_run(input int len, input int mode);
        int     pc;
        int     cnt;
        bit     fin;
        bit     err;
        int     off;
        int     k;
        int     ws;
        bit     mvi;
        issue_t it;
        end_t   et;
        pc = 0; cnt = 0; fin = (len == 0); err = 0; off = -1;
        while (!fin && !err) begin
            it.din     = mem_m[pc % DEPTH];
            it.pc      = pc;
            mvi        = (it.din[8:6] == 3'b001);
            it.has_imm = mvi && (pc + 1 < len);
            it.imm     = mem_m[(pc + 1) % DEPTH];
            issue_q.push_back(it);
            ws = mvi ? 2 : 1;
            k  = pick_k(mode, ws);
            delay_q.push_back(k);
            if (mvi && pc + 1 >= len) begin
                err = 1; off = 1;
            end else if (k >= ws && k < ws + TIMEOUT) begin
                cnt = (cnt < 255) ? cnt + 1 : 255;
                pc  = pc + (mvi ? 2 : 1);
                if (pc >= len) begin
                    fin = 1; off = k + 1;
                end
            end else begin
                err = 1; off = ws + TIMEOUT;
            end
        end
        et.fin = fin; et.err = err; et.cnt = cnt; et.pc = pc; et.off = off;
        end_q.push_back(et);
    endtask

    task automatic do_reset();
        @(posedge Clock); #1;
        Reset = 1'b1;
        in_idle = 1'b1;
        issue_q.delete(); end_q.delete(); delay_q.delete();
        #2;
        check("rst_din", 32'(bus.DIN), 0);
        check("rst_run", 32'(bus.Run), 0);
        check("rst_busy", 32'(bus.Busy), 0);
        check("rst_finished", 32'(bus.Finished), 0);
        check("rst_error", 32'(bus.Error), 0);
        check("rst_pc", 32'(bus.Pc), 0);
        check("rst_instr_count", 32'(bus.Instr_count), 0);
        @(posedge Clock); #1;
        Reset = 1'b0;
    endtask

    task automatic load_word(input int addr, input logic [15:0] data);
        @(posedge Clock); #1;
        bus.Load_en   = 1'b1;
        bus.Load_addr = AW'(addr);
        bus.Load_data = data;
        if (in_idle) mem_m[addr] = data;
        @(posedge Clock); #1;
        bus.Load_en = 1'b0;
    endtask

    task automatic start_prog(input int len, input int mode, input bit with_load);
        model_run(len, mode);
        @(posedge Clock); #1;
        bus.Start    = 1'b1;
        bus.Prog_len = (AW+1)'(len);
        if (with_load) begin
            bus.Load_en   = 1'b1;
            bus.Load_addr = '0;
            bus.Load_data = 16'hFFFF;
        end
        @(posedge Clock); #1;
        bus.Start   = 1'b0;
        bus.Load_en = 1'b0;
        in_idle     = 1'b0;
    endtask

    task automatic wait_end();
        int i;
        i = 0;
        while (armed && i < 3000) begin
            @(posedge Clock);
            i++;
        end
        if (armed) begin
            n_cmp++; n_bad++;
            $display("FAIL run_end: still busy after %0d cycles, required halt", i);
        end
        repeat (TIMEOUT + 6) @(posedge Clock);
    endtask

    // Processor stand-in: answer each Run with a one-cycle Done after the queued delay.
    initial begin : responder
        bus.Done = 1'b0;
        forever begin
            @(negedge Clock);
            if (bus.Run && !Reset) begin
                int k;
                k = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
                if (k > 0) begin
                    repeat (k) @(posedge Clock);
                    #1 bus.Done = 1'b1;
                    @(posedge Clock);
                    #1 bus.Done = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: compares every Run, immediate word and end-of-run status.
    initial begin : monitor
        int     cyc;
        int     cyc_run;
        bit     prev_run;
        bit     imm_pending;
        logic [15:0] imm_exp;
        issue_t it;
        end_t   et;
        cyc = 0; cyc_run = 0; prev_run = 0; imm_pending = 0; imm_exp = '0;
        forever begin
            @(negedge Clock);
            cyc++;
            if (Reset) begin
                prev_run = 0; imm_pending = 0; armed = 0;
                continue;
            end
            if (imm_pending) begin
                check("imm_din", 32'(bus.DIN), 32'(imm_exp));
                check("imm_run_low", 32'(bus.Run), 0);
                imm_pending = 0;
            end
            if (bus.Run) begin
                check("run_gap", 32'(prev_run), 0);
                check("run_expected", 32'(issue_q.size() != 0), 1);
                if (issue_q.size() != 0) begin
                    it = issue_q.pop_front();
                    check("issue_din", 32'(bus.DIN), 32'(it.din));
                    check("issue_pc", 32'(bus.Pc), 32'(it.pc));
                    imm_pending = it.has_imm;
                    imm_exp     = it.imm;
                end
                cyc_run = cyc;
            end
            prev_run = bus.Run;
            if (armed && !bus.Busy) begin
                armed = 0;
                check("end_expected", 32'(end_q.size() != 0), 1);
                if (end_q.size() != 0) begin
                    et = end_q.pop_front();
                    check("end_finished", 32'(bus.Finished), 32'(et.fin));
                    check("end_error", 32'(bus.Error), 32'(et.err));
                    check("end_instr_count", 32'(bus.Instr_count), 32'(et.cnt));
                    check("end_pc", 32'(bus.Pc), 32'(et.pc));
                    check("end_no_leftover_issue", 32'(issue_q.size()), 0);
                    if (et.off >= 0) check("end_halt_offset", 32'(cyc - cyc_run), 32'(et.off));
                end
            end
            if (bus.Start && !bus.Busy) armed = 1;
        end
    end

    initial begin : stim
        logic [15:0] w;
        Reset = 1'b1;
        bus.Start = 1'b0; bus.Load_en = 1'b0; bus.Load_addr = '0;
        bus.Load_data = '0; bus.Prog_len = '0;
        repeat (2) @(posedge Clock);
        do_reset();
        for (int i = 0; i < DEPTH; i++) load_word(i, 16'($urandom));

        // mvi R0,#5 with Done three cycles after Run.
        load_word(0, 16'h0040);
        load_word(1, 16'h0005);
        fixed_k = 3;
        start_prog(2, 3, 0);
        wait_end();

        // Load while halted is dropped; after reset the same program runs again.
        load_word(0, 16'h1234);
        do_reset();
        start_prog(2, 3, 0);
        wait_end();

        // mvi R0,#5; mvi R1,#3; add R0,R1.
        do_reset();
        load_word(0, 16'h0040); load_word(1, 16'h0005); load_word(2, 16'h0048);
        load_word(3, 16'h0003); load_word(4, 16'h0081);
        start_prog(5, 3, 0);
        wait_end();

        // Truncated mvi at the last word.
        do_reset();
        load_word(0, 16'h0040);
        start_prog(1, 0, 0);
        wait_end();

        // Done never arrives: timeout.
        do_reset();
        load_word(0, 16'h0081); load_word(1, 16'h0048); load_word(2, 16'h0081);
        start_prog(3, 2, 0);
        wait_end();

        // Empty program restarted from HALT.
        start_prog(0, 0, 0);
        wait_end();

        // Reset in the middle of WAIT, then an identical rerun.
        do_reset();
        start_prog(3, 2, 0);
        repeat (6) @(posedge Clock);
        do_reset();
        fixed_k = 4;
        start_prog(3, 3, 0);
        wait_end();

        // Start together with Load_en: start wins, memory untouched.
        do_reset();
        start_prog(3, 3, 1);
        wait_end();

        // Load and Start while busy are both ignored.
        do_reset();
        fixed_k = 7;
        start_prog(3, 3, 0);
        load_word(2, 16'hBEEF);
        @(posedge Clock); #1;
        bus.Start = 1'b1; bus.Prog_len = 6'd1;
        @(posedge Clock); #1;
        bus.Start = 1'b0;
        wait_end();

        // Random programs with random processor timing.
        for (int r = 0; r < 12; r++) begin
            do_reset();
            for (int i = 0; i < DEPTH; i++) begin
                w = 16'($urandom);
                if ($urandom_range(0, 2) == 0) w[8:6] = 3'b001;
                load_word(i, w);
            end
            start_prog(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, DEPTH), 1, 0);
            wait_end();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "time limit");
    end
endmodule
